// File: rtl/thermal_shutdown_ctrl_if.sv
// Signal bundle between the thermal supervisor side and the shutdown controller.
// The master drives the sensor flag and the restart request. The slave (the controller) drives the power and status outputs.
interface thermal_shutdown_ctrl_if;
  logic       cpu_overheated;
  logic       restart_req;
  logic       shut_off_computer;
  logic       overheat_warn;
  logic       restart_ready;
  logic       restart_ack;
  logic       lockout;
  logic [3:0] trip_count;

  modport master (
    output cpu_overheated, restart_req,
    input  shut_off_computer, overheat_warn, restart_ready, restart_ack,
           lockout, trip_count
  );

  modport slave (
    input  cpu_overheated, restart_req,
    output shut_off_computer, overheat_warn, restart_ready, restart_ack,
           lockout, trip_count
  );
endinterface

// File: rtl/thermal_shutdown_ctrl.sv
// Debounced, hysteretic computer shut-off sequencer with cool-down, restart
// handshake and a sticky lockout after repeated trips.
module thermal_shutdown_ctrl #(
  parameter int unsigned TRIP_CYCLES = 4,
  parameter int unsigned COOL_CYCLES = 8,
  parameter int unsigned MAX_TRIPS   = 3
) (
  input logic                    clk,
  input logic                    areset,
  thermal_shutdown_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_WARN,
    ST_OFF,
    ST_READY,
    ST_LOCK
  } state_t;

  state_t     state;
  logic [7:0] pcnt;
  logic [7:0] ccnt;
  logic [3:0] trip_count;
  logic [3:0] trip_next;
  logic       shut_off_q;
  logic       warn_q;
  logic       ready_q;
  logic       ack_q;
  logic       lockout_q;

  // The trip count saturates. This guard is kept even though LOCK normally stops further increments.
  always_comb begin
    trip_next = trip_count;
    if (trip_count != 4'(MAX_TRIPS)) trip_next = trip_count + 4'd1;
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state      <= ST_RUN;
      pcnt       <= '0;
      ccnt       <= '0;
      trip_count <= '0;
      shut_off_q <= 1'b0;
      warn_q     <= 1'b0;
      ready_q    <= 1'b0;
      ack_q      <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state)
        ST_RUN: begin
          if (bus.cpu_overheated) begin
            state  <= ST_WARN;
            pcnt   <= 8'd1;
            warn_q <= 1'b1;
          end
        end

        ST_WARN: begin
          if (!bus.cpu_overheated) begin
            state  <= ST_RUN;
            pcnt   <= '0;
            warn_q <= 1'b0;
          end else if (pcnt + 8'd1 == 8'(TRIP_CYCLES)) begin
            pcnt       <= '0;
            trip_count <= trip_next;
            warn_q     <= 1'b0;
            shut_off_q <= 1'b1;
            if (trip_next == 4'(MAX_TRIPS)) begin
              state     <= ST_LOCK;
              lockout_q <= 1'b1;
            end else begin
              state <= ST_OFF;
              ccnt  <= '0;
            end
          end else begin
            pcnt <= pcnt + 8'd1;
          end
        end

        ST_OFF: begin
          if (bus.cpu_overheated) begin
            ccnt <= '0;
          end else if (ccnt + 8'd1 == 8'(COOL_CYCLES)) begin
            state   <= ST_READY;
            ccnt    <= '0;
            ready_q <= 1'b1;
          end else begin
            ccnt <= ccnt + 8'd1;
          end
        end

        // A renewed overheat outranks a pending restart request.
        ST_READY: begin
          if (bus.cpu_overheated) begin
            state   <= ST_OFF;
            ccnt    <= '0;
            ready_q <= 1'b0;
          end else if (bus.restart_req) begin
            state      <= ST_RUN;
            ready_q    <= 1'b0;
            shut_off_q <= 1'b0;
            ack_q      <= 1'b1;
          end
        end

        ST_LOCK: begin
        end

        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  assign bus.shut_off_computer = shut_off_q;
  assign bus.overheat_warn     = warn_q;
  assign bus.restart_ready     = ready_q;
  assign bus.restart_ack       = ack_q;
  assign bus.lockout           = lockout_q;
  assign bus.trip_count        = trip_count;

endmodule

// File: tb/tb_thermal_shutdown_ctrl.sv
// Directed bench for thermal_shutdown_ctrl: a streak-counting reference model
// checked every cycle, plus hand-computed expectations along the scenario.
module tb_thermal_shutdown_ctrl;
  localparam int TRIP = 4;
  localparam int COOL = 8;
  localparam int MAXT = 3;

  logic clk = 1'b0;
  logic areset;
  int   n_pass = 0;
  int   n_total = 0;

  thermal_shutdown_ctrl_if bus ();

  thermal_shutdown_ctrl #(
    .TRIP_CYCLES(TRIP),
    .COOL_CYCLES(COOL),
    .MAX_TRIPS  (MAXT)
  ) dut (
    .clk   (clk),
    .areset(areset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: the power state is tracked as streaks of consecutive samples.
  int hot_streak = 0;
  int cool_streak = 0;
  int trips = 0;
  bit m_off = 0, m_ready = 0, m_locked = 0, m_ack = 0;

  always @(posedge clk or posedge areset) begin
    if (areset) begin
      hot_streak = 0; cool_streak = 0; trips = 0;
      m_off = 0; m_ready = 0; m_locked = 0; m_ack = 0;
    end else begin
      m_ack = 0;
      if (m_locked) begin
      end else if (!m_off) begin
        if (bus.cpu_overheated) begin
          hot_streak++;
          if (hot_streak == TRIP) begin
            hot_streak = 0;
            trips++;
            m_off = 1;
            cool_streak = 0;
            if (trips == MAXT) m_locked = 1;
          end
        end else hot_streak = 0;
      end else if (bus.cpu_overheated) begin
        cool_streak = 0;
        m_ready = 0;
      end else if (m_ready) begin
        if (bus.restart_req) begin
          m_off = 0; m_ready = 0; m_ack = 1;
        end
      end else begin
        cool_streak++;
        if (cool_streak == COOL) m_ready = 1;
      end
    end
  end

  function automatic logic [8:0] dut_vec();
    return {bus.shut_off_computer, bus.overheat_warn, bus.restart_ready,
            bus.restart_ack, bus.lockout, bus.trip_count};
  endfunction

  function automatic logic [8:0] model_vec();
    return {m_off, (!m_off && hot_streak > 0), m_ready, m_ack, m_locked, 4'(trips)};
  endfunction

  always @(negedge clk) check("cycle_vs_model", 32'(dut_vec()), 32'(model_vec()));

  // Drive one sample and return just after the capturing edge.
  task automatic cyc(input bit oh, input bit req);
    bus.cpu_overheated = oh;
    bus.restart_req    = req;
    @(posedge clk);
    #1;
  endtask

  task automatic cool_and_restart();
    repeat (COOL) cyc(0, 0);
    check("ready_after_cool", 32'(bus.restart_ready), 1);
    cyc(0, 1);
    check("restart_ack_pulse", 32'(bus.restart_ack), 1);
    check("restart_power_on", 32'(bus.shut_off_computer), 0);
  endtask

  bit seen_ready, seen_ack;

  initial begin
    areset = 1'b1;
    bus.cpu_overheated = 1'b0;
    bus.restart_req    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(dut_vec()), 0);
    areset = 1'b0;

    // Glitch filter: three highs then low.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0);
      check("glitch_warn", 32'(bus.overheat_warn), 1);
      check("glitch_no_shut", 32'(bus.shut_off_computer), 0);
    end
    cyc(0, 0);
    check("glitch_clear", 32'(dut_vec()), 0);

    // First trip.
    repeat (3) cyc(1, 0);
    check("pre_trip_shut", 32'(bus.shut_off_computer), 0);
    cyc(1, 0);
    check("trip1_vec", 32'(dut_vec()), 32'(9'b1_0000_0001));

    // Cool-down interrupted by one high, then a full cool-down.
    repeat (5) cyc(0, 0);
    cyc(1, 0);
    repeat (COOL - 1) cyc(0, 0);
    check("cool_not_yet", 32'(bus.restart_ready), 0);
    cyc(0, 0);
    check("cool_ready", 32'(dut_vec()), 32'(9'b1_0100_0001));
    cyc(0, 1);
    check("restart_vec", 32'(dut_vec()), 32'(9'b0_0010_0001));
    cyc(0, 0);
    check("ack_drops", 32'(bus.restart_ack), 0);

    // Second trip, then overheat outranking restart_req in READY.
    repeat (TRIP) cyc(1, 0);
    check("trip2_count", 32'(bus.trip_count), 2);
    repeat (COOL) cyc(0, 0);
    cyc(1, 1);
    check("prio_vec", 32'(dut_vec()), 32'(9'b1_0000_0010));
    repeat (COOL - 1) cyc(0, 0);
    check("prio_cool_restarts", 32'(bus.restart_ready), 0);
    cyc(0, 0);
    cyc(0, 1);
    check("restart2_ack", 32'(bus.restart_ack), 1);

    // High sample on the first RUN cycle enters WARN; third trip locks.
    cyc(1, 0);
    check("no_immunity_warn", 32'(bus.overheat_warn), 1);
    repeat (TRIP - 1) cyc(1, 0);
    check("lock_vec", 32'(dut_vec()), 32'(9'b1_0001_0011));
    seen_ready = 0;
    seen_ack = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1);
      seen_ready |= bus.restart_ready;
      seen_ack   |= bus.restart_ack;
    end
    check("lock_no_ready", 32'(seen_ready), 0);
    check("lock_no_ack", 32'(seen_ack), 0);
    check("lock_held", 32'(bus.lockout), 1);

    // Async reset between edges in LOCK.
    #2 areset = 1'b1;
    #1 check("areset_lock", 32'(dut_vec()), 0);
    @(posedge clk);
    #1 areset = 1'b0;

    // Fresh trip into OFF, then async reset there.
    repeat (TRIP) cyc(1, 0);
    check("fresh_trip_count", 32'(bus.trip_count), 1);
    cyc(0, 0);
    #2 areset = 1'b1;
    #1 check("areset_off", 32'(dut_vec()), 0);
    @(posedge clk);
    #1 areset = 1'b0;
    cyc(1, 0);
    check("post_reset_warn", 32'(dut_vec()), 32'(9'b0_1000_0000));
    cyc(0, 0);
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
